// File: rtl/vdiv_seq_if.sv
// Handshake bundle for the vector divide sequencer.
//   vin_*   : vector request from the issue stage (sequencer accepts)
//   vout_*  : result vector towards the consumer (sequencer offers)
//   div_*   : scalar divider link (sequencer is the initiator)
// master = sequencer side, slave = environment side (issue stage, consumer, divider).
interface vdiv_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 4
);
  logic                   vin_valid;
  logic                   vin_ready;
  logic [LANES*WIDTH-1:0] vin_a;
  logic [LANES*WIDTH-1:0] vin_b;
  logic [LANES-1:0]       vin_mask;

  logic                   vout_valid;
  logic                   vout_ready;
  logic [LANES*WIDTH-1:0] vout_result;
  logic [LANES-1:0]       vout_mask;
  logic [LANES-1:0]       vout_nan;

  logic [WIDTH-1:0]       div_operand1;
  logic [WIDTH-1:0]       div_operand2;
  logic                   div_valid_in;
  logic                   div_ready_in;
  logic [WIDTH-1:0]       div_result;
  logic                   div_valid_out;
  logic                   div_ready_out;

  modport master (
    input  vin_valid, vin_a, vin_b, vin_mask,
    output vin_ready,
    output vout_valid, vout_result, vout_mask, vout_nan,
    input  vout_ready,
    output div_operand1, div_operand2, div_valid_in, div_ready_out,
    input  div_ready_in, div_result, div_valid_out
  );

  modport slave (
    output vin_valid, vin_a, vin_b, vin_mask,
    input  vin_ready,
    input  vout_valid, vout_result, vout_mask, vout_nan,
    output vout_ready,
    input  div_operand1, div_operand2, div_valid_in, div_ready_out,
    output div_ready_in, div_result, div_valid_out
  );
endinterface

// File: rtl/vdiv_seq.sv
// Vector divide sequencer: accepts a vector of LANES operand pairs, issues the
// active lanes one at a time (ascending index) to a shared scalar divider and
// reassembles the quotients plus a per-lane NaN flag into one result vector.
// Ports:
//   CLK   - clock, all state on rising edge
//   nRST  - asynchronous active-low reset
//   bus   - vdiv_seq_if.master: vin_* request, vout_* result, div_* divider link
//   busy  - sequencer is not idle
module vdiv_seq #(
  parameter  int unsigned EXP_WIDTH  = 8,
  parameter  int unsigned MANT_WIDTH = 7,
  parameter  int unsigned LANES      = 4,
  localparam int unsigned WIDTH      = EXP_WIDTH + MANT_WIDTH + 1
) (
  input  logic        CLK,
  input  logic        nRST,
  vdiv_seq_if.master  bus,
  output logic        busy
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   init_q;
  logic [LANES*WIDTH-1:0] a_q, b_q, res_q;
  logic [LANES-1:0]       mask_q, nan_q;
  logic [LW-1:0]          lane_q;

  logic                   first_found, next_found;
  logic [LW-1:0]          first_idx, next_idx;
  logic                   res_nan;

  // Lowest set bit of the incoming mask, and lowest set bit of the captured
  // mask strictly above the current lane. Scanning downwards lets the last
  // hit be the lowest index.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = LANES; i > 0; i--) begin
      if (bus.vin_mask[i-1]) begin
        first_found = 1'b1;
        first_idx   = LW'(i - 1);
      end
      if (mask_q[i-1] && ((i - 1) > 32'(lane_q))) begin
        next_found = 1'b1;
        next_idx   = LW'(i - 1);
      end
    end
  end

  assign res_nan = (&bus.div_result[WIDTH-2 -: EXP_WIDTH]) &&
                   (|bus.div_result[MANT_WIDTH-1:0]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.vin_ready     = 1'b0;
    bus.vout_valid    = 1'b0;
    bus.div_valid_in  = 1'b0;
    bus.div_ready_out = 1'b0;
    bus.div_operand1  = '0;
    bus.div_operand2  = '0;
    unique case (state_q)
      IDLE: begin
        // init_q keeps vin_ready low until the first edge after reset release.
        bus.vin_ready = init_q;
        if (bus.vin_valid && init_q) state_d = first_found ? ISSUE : DONE;
      end
      ISSUE: begin
        bus.div_valid_in = 1'b1;
        bus.div_operand1 = a_q[lane_q*WIDTH +: WIDTH];
        bus.div_operand2 = b_q[lane_q*WIDTH +: WIDTH];
        if (bus.div_ready_in) state_d = WAIT;
      end
      WAIT: begin
        bus.div_ready_out = 1'b1;
        if (bus.div_valid_out) state_d = next_found ? ISSUE : DONE;
      end
      DONE: begin
        bus.vout_valid = 1'b1;
        if (bus.vout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      init_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      mask_q <= '0;
      nan_q  <= '0;
      lane_q <= '0;
    end else begin
      init_q <= 1'b1;
      if (state_q == IDLE && bus.vin_valid && init_q) begin
        a_q    <= bus.vin_a;
        b_q    <= bus.vin_b;
        mask_q <= bus.vin_mask;
        res_q  <= '0;
        nan_q  <= '0;
        lane_q <= first_idx;
      end
      if (state_q == WAIT && bus.div_valid_out) begin
        res_q[lane_q*WIDTH +: WIDTH] <= bus.div_result;
        nan_q[lane_q]                <= res_nan;
        if (next_found) lane_q <= next_idx;
      end
    end
  end

  assign bus.vout_result = res_q;
  assign bus.vout_mask   = mask_q;
  assign bus.vout_nan    = nan_q;
  assign busy            = (state_q != IDLE);

endmodule
